// File: rtl/ieeedrv_pkg.sv
// Shared types and helpers for the dual-unit track-buffer scheduler.
package ieeedrv_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER} sched_st_t;
   typedef enum logic {OP_LOAD, OP_SAVE} op_t;

   // Track numbers are 1-based; track 0 maps to the first slot.
   function automatic logic [31:0] trk2lba(input logic [7:0] trk, input logic [31:0] blk_per_tr);
      logic [31:0] t32;
      t32 = (trk == 8'd0) ? 32'd1 : {24'd0, trk};
      return (t32 - 32'd1) * blk_per_tr;
   endfunction

endpackage

// File: rtl/ieeedrv_req_track.sv
// Per-unit request capture: save toggle / head-settle edge detection and buffer bookkeeping.
module ieeedrv_req_track (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       mounted,
   input  logic       save_track,
   input  logic [7:0] track,
   input  logic       track_changing,
   input  logic       clr_save,
   input  logic       clr_load,
   input  logic       set_loaded,
   input  logic       set_error,
   input  logic [7:0] load_trk,
   output logic       save_pend,
   output logic       load_pend,
   output logic       loaded,
   output logic [7:0] loaded_trk,
   output logic       error
);

   logic       save_ref_reg, ref_valid_reg, tc_prev_reg;
   logic       save_pend_reg, save_pend_next;
   logic       load_pend_reg, load_pend_next;
   logic       loaded_reg, loaded_next;
   logic [7:0] loaded_trk_reg, loaded_trk_next;
   logic       error_reg, error_next;
   logic       save_evt, trk_evt;

   // The toggle reference is only trusted after one post-reset sample.
   assign save_evt = ref_valid_reg && (save_track != save_ref_reg);
   assign trk_evt  = tc_prev_reg && !track_changing && (track != loaded_trk_reg);

   always_comb begin
      save_pend_next  = save_pend_reg;
      load_pend_next  = load_pend_reg;
      loaded_next     = loaded_reg;
      loaded_trk_next = loaded_trk_reg;
      error_next      = error_reg;
      // Clears from completion come first so a same-cycle capture overrides them.
      if (clr_save)              save_pend_next = 1'b0;
      if (save_evt && loaded_reg) save_pend_next = 1'b1;
      if (mounted)               save_pend_next = 1'b0;
      if (clr_load)              load_pend_next = 1'b0;
      if (mounted || trk_evt)    load_pend_next = 1'b1;
      if (set_loaded) begin
         loaded_next     = 1'b1;
         loaded_trk_next = load_trk;
      end
      if (mounted)   loaded_next = 1'b0;
      if (mounted)   error_next  = 1'b0;
      if (set_error) error_next  = 1'b1;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         save_ref_reg   <= 1'b0;
         ref_valid_reg  <= 1'b0;
         tc_prev_reg    <= 1'b0;
         save_pend_reg  <= 1'b0;
         load_pend_reg  <= 1'b0;
         loaded_reg     <= 1'b0;
         loaded_trk_reg <= 8'd0;
         error_reg      <= 1'b0;
      end else begin
         save_ref_reg   <= save_track;
         ref_valid_reg  <= 1'b1;
         tc_prev_reg    <= track_changing;
         save_pend_reg  <= save_pend_next;
         load_pend_reg  <= load_pend_next;
         loaded_reg     <= loaded_next;
         loaded_trk_reg <= loaded_trk_next;
         error_reg      <= error_next;
      end
   end

   assign save_pend  = save_pend_reg;
   assign load_pend  = load_pend_reg;
   assign loaded     = loaded_reg;
   assign loaded_trk = loaded_trk_reg;
   assign error      = error_reg;

endmodule

// File: rtl/ieeedrv_track_sched.sv
// Round-robin scheduler of track load/save transfers over one shared SD block port.
module ieeedrv_track_sched #(
   parameter int          NDRV       = 2,
   parameter int          BLK_PER_TR = 8,
   parameter logic [23:0] TIMEOUT    = 24'hFFFFFF
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic [NDRV-1:0]   mounted,
   input  logic [NDRV-1:0]   save_track,
   input  logic [NDRV*8-1:0] track,
   input  logic [NDRV-1:0]   track_changing,
   output logic [31:0]       sd_lba,
   output logic [5:0]        sd_blk_cnt,
   output logic [NDRV-1:0]   sd_rd,
   output logic [NDRV-1:0]   sd_wr,
   input  logic [NDRV-1:0]   sd_ack,
   output logic              buf_sel,
   output logic [NDRV-1:0]   busy,
   output logic [NDRV-1:0]   loaded,
   output logic [NDRV-1:0]   error
);
   import ieeedrv_pkg::*;

   localparam logic [31:0] BLK = 32'(BLK_PER_TR);

   sched_st_t   st_reg, st_next;
   op_t         op_reg, op_next;
   logic        cur_reg, cur_next, last_reg, last_next, abort_reg, abort_next;
   logic [31:0] lba_reg, lba_next;
   logic [7:0]  trk_reg, trk_next;
   logic [23:0] wd_reg, wd_next;

   logic [NDRV-1:0] save_pend, load_pend, cand, active;
   logic [NDRV-1:0] clr_save, clr_load, set_loaded, set_error;
   logic [7:0]      trk_u [NDRV];
   logic [7:0]      loaded_trk [NDRV];
   logic            found, pick, abort_eff, wd_expired;
   int              arb_idx;

   generate
      for (genvar gi = 0; gi < NDRV; gi++) begin : g_unit
         assign trk_u[gi]  = track[8*gi +: 8];
         assign cand[gi]   = (save_pend[gi] | load_pend[gi]) & ~track_changing[gi];
         assign active[gi] = (st_reg != ST_IDLE) && (int'(cur_reg) == gi);
         ieeedrv_req_track u_req (
            .clk_sys        (clk_sys),
            .reset_n        (reset_n),
            .mounted        (mounted[gi]),
            .save_track     (save_track[gi]),
            .track          (trk_u[gi]),
            .track_changing (track_changing[gi]),
            .clr_save       (clr_save[gi]),
            .clr_load       (clr_load[gi]),
            .set_loaded     (set_loaded[gi]),
            .set_error      (set_error[gi]),
            .load_trk       (trk_reg),
            .save_pend      (save_pend[gi]),
            .load_pend      (load_pend[gi]),
            .loaded         (loaded[gi]),
            .loaded_trk     (loaded_trk[gi]),
            .error          (error[gi])
         );
      end
   endgenerate

   always_comb begin
      found   = 1'b0;
      pick    = 1'b0;
      arb_idx = 0;
      for (int k = 1; k <= NDRV; k++) begin
         arb_idx = (int'(last_reg) + k) % NDRV;
         if (!found && cand[arb_idx]) begin
            found = 1'b1;
            pick  = 1'(arb_idx);
         end
      end
   end

   // A remount during the transfer invalidates the image being loaded.
   assign abort_eff  = abort_reg | mounted[cur_reg];
   assign wd_expired = (wd_reg == TIMEOUT - 24'd1);

   always_comb begin
      st_next    = st_reg;
      op_next    = op_reg;
      cur_next   = cur_reg;
      last_next  = last_reg;
      abort_next = abort_reg;
      lba_next   = lba_reg;
      trk_next   = trk_reg;
      wd_next    = wd_reg + 24'd1;
      clr_save   = '0;
      clr_load   = '0;
      set_loaded = '0;
      set_error  = '0;
      case (st_reg)
         ST_IDLE: begin
            wd_next = 24'd0;
            if (found) begin
               cur_next   = pick;
               last_next  = pick;
               abort_next = mounted[pick];
               trk_next   = trk_u[pick];
               if (save_pend[pick]) begin
                  op_next  = OP_SAVE;
                  lba_next = trk2lba(loaded_trk[pick], BLK);
               end else begin
                  op_next  = OP_LOAD;
                  lba_next = trk2lba(trk_u[pick], BLK);
               end
               st_next = ST_REQ;
            end
         end
         ST_REQ, ST_XFER: begin
            abort_next = abort_eff;
            if (st_reg == ST_REQ && sd_ack[cur_reg]) begin
               st_next = ST_XFER;
               wd_next = 24'd0;
            end else if (st_reg == ST_XFER && !sd_ack[cur_reg]) begin
               st_next = ST_IDLE;
               if (op_reg == OP_SAVE) begin
                  clr_save[cur_reg] = 1'b1;
               end else if (!abort_eff) begin
                  clr_load[cur_reg]   = 1'b1;
                  set_loaded[cur_reg] = 1'b1;
               end
            end else if (wd_expired) begin
               st_next            = ST_IDLE;
               set_error[cur_reg] = 1'b1;
               if (op_reg == OP_SAVE) clr_save[cur_reg] = 1'b1;
               else if (!abort_eff)   clr_load[cur_reg] = 1'b1;
            end
         end
         default: st_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         st_reg    <= ST_IDLE;
         op_reg    <= OP_LOAD;
         cur_reg   <= 1'b0;
         last_reg  <= 1'b0;
         abort_reg <= 1'b0;
         lba_reg   <= 32'd0;
         trk_reg   <= 8'd0;
         wd_reg    <= 24'd0;
      end else begin
         st_reg    <= st_next;
         op_reg    <= op_next;
         cur_reg   <= cur_next;
         last_reg  <= last_next;
         abort_reg <= abort_next;
         lba_reg   <= lba_next;
         trk_reg   <= trk_next;
         wd_reg    <= wd_next;
      end
   end

   always_comb begin
      sd_rd = '0;
      sd_wr = '0;
      if (st_reg == ST_REQ) begin
         if (op_reg == OP_LOAD) sd_rd[cur_reg] = 1'b1;
         else                   sd_wr[cur_reg] = 1'b1;
      end
   end

   assign sd_lba     = lba_reg;
   assign sd_blk_cnt = 6'(BLK_PER_TR - 1);
   assign buf_sel    = cur_reg;
   assign busy       = save_pend | load_pend | active;

endmodule

// File: tb/tb_ieeedrv_track_sched.sv
// Directed scenario bench for the shared track-buffer scheduler.
module tb_ieeedrv_track_sched;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  mounted = 2'b00;
   logic [1:0]  save_track = 2'b00;
   logic [15:0] track = {8'd1, 8'd1};
   logic [1:0]  track_changing = 2'b00;
   logic [1:0]  sd_ack = 2'b00;
   logic [31:0] sd_lba;
   logic [5:0]  sd_blk_cnt;
   logic [1:0]  sd_rd, sd_wr, busy, loaded, error;
   logic        buf_sel;

   int checks = 0;
   int errors = 0;

   always #5 clk_sys = ~clk_sys;

   ieeedrv_track_sched #(.NDRV(2), .BLK_PER_TR(8), .TIMEOUT(24'd100)) dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .mounted        (mounted),
      .save_track     (save_track),
      .track          (track),
      .track_changing (track_changing),
      .sd_lba         (sd_lba),
      .sd_blk_cnt     (sd_blk_cnt),
      .sd_rd          (sd_rd),
      .sd_wr          (sd_wr),
      .sd_ack         (sd_ack),
      .buf_sel        (buf_sel),
      .busy           (busy),
      .loaded         (loaded),
      .error          (error)
   );

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) @(negedge clk_sys);
   endtask

   task automatic pulse_mounted(input logic [1:0] m);
      mounted = m;
      tick();
      mounted = 2'b00;
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if ((sd_rd | sd_wr) != 2'b00) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic ack(input int d);
      sd_ack[d] = 1'b1;
      tick();
      sd_ack[d] = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      tick(3);
      checks++;
      if ({sd_rd, sd_wr, busy, loaded, error, buf_sel} !== 11'd0 || sd_lba !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs got rd=%b wr=%b busy=%b ld=%b err=%b sel=%b lba=%0d want all 0",
                  sd_rd, sd_wr, busy, loaded, error, buf_sel, sd_lba);
      end
      checks++;
      if (sd_blk_cnt !== 6'd7) begin
         errors++;
         $display("FAIL blk_cnt got %0d want 7", sd_blk_cnt);
      end
      reset_n = 1'b1;
      tick(5);
      checks++;
      if ((sd_rd | sd_wr) !== 2'b00 || busy !== 2'b00) begin
         errors++;
         $display("FAIL post_reset_idle got rd=%b wr=%b busy=%b want 0", sd_rd, sd_wr, busy);
      end
      $display("test_reset done");
   endtask

   task automatic test_save_unloaded;
      bit seen = 1'b0;
      save_track[1] = ~save_track[1];
      for (int i = 0; i < 10; i++) begin
         tick();
         if ((sd_wr | sd_rd) != 2'b00 || busy != 2'b00) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL save_unloaded got transfer_seen=%b want 0", seen);
      end
      $display("test_save_unloaded done");
   endtask

   task automatic test_load;
      bit ok;
      track[7:0] = 8'd18;
      pulse_mounted(2'b01);
      wait_req(ok);
      checks++;
      if (!ok || sd_rd !== 2'b01 || sd_wr !== 2'b00 || sd_lba !== 32'd136 || buf_sel !== 1'b0) begin
         errors++;
         $display("FAIL load_req got ok=%b rd=%b wr=%b lba=%0d sel=%b want rd=01 lba=136 sel=0",
                  ok, sd_rd, sd_wr, sd_lba, buf_sel);
      end
      sd_ack[0] = 1'b1;
      tick();
      checks++;
      if (sd_rd !== 2'b00 || busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL load_xfer got rd=%b busy=%b want rd=00 busy0=1", sd_rd, busy);
      end
      sd_ack[0] = 1'b0;
      tick();
      checks++;
      if (loaded[0] !== 1'b1 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL load_done got loaded=%b busy=%b want loaded0=1 busy0=0", loaded, busy);
      end
      $display("test_load done: unit0 track 18");
   endtask

   task automatic test_save_then_load;
      bit ok;
      save_track[0] = ~save_track[0];
      tick();
      track_changing[0] = 1'b1;
      track[7:0] = 8'd19;
      tick(2);
      track_changing[0] = 1'b0;
      wait_req(ok);
      checks++;
      if (!ok || sd_wr !== 2'b01 || sd_rd !== 2'b00 || sd_lba !== 32'd136) begin
         errors++;
         $display("FAIL save_first got ok=%b wr=%b rd=%b lba=%0d want wr=01 lba=136",
                  ok, sd_wr, sd_rd, sd_lba);
      end
      ack(0);
      wait_req(ok);
      checks++;
      if (!ok || sd_rd !== 2'b01 || sd_lba !== 32'd144) begin
         errors++;
         $display("FAIL load_after_save got ok=%b rd=%b lba=%0d want rd=01 lba=144", ok, sd_rd, sd_lba);
      end
      ack(0);
      checks++;
      if (busy !== 2'b00 || loaded[0] !== 1'b1) begin
         errors++;
         $display("FAIL step_done got busy=%b loaded=%b want busy=00 loaded0=1", busy, loaded);
      end
      $display("test_save_then_load done: save 136, load 144");
   endtask

   task automatic test_round_robin;
      bit ok;
      track = {8'd5, 8'd7};
      pulse_mounted(2'b11);
      wait_req(ok);
      checks++;
      if (!ok || sd_rd !== 2'b10 || sd_lba !== 32'd32 || buf_sel !== 1'b1) begin
         errors++;
         $display("FAIL rr_first got ok=%b rd=%b lba=%0d sel=%b want rd=10 lba=32 sel=1",
                  ok, sd_rd, sd_lba, buf_sel);
      end
      ack(1);
      wait_req(ok);
      checks++;
      if (!ok || sd_rd !== 2'b01 || sd_lba !== 32'd48 || buf_sel !== 1'b0) begin
         errors++;
         $display("FAIL rr_second got ok=%b rd=%b lba=%0d sel=%b want rd=01 lba=48 sel=0",
                  ok, sd_rd, sd_lba, buf_sel);
      end
      ack(0);
      checks++;
      if (loaded !== 2'b11 || busy !== 2'b00) begin
         errors++;
         $display("FAIL rr_done got loaded=%b busy=%b want 11 00", loaded, busy);
      end
      $display("test_round_robin done: unit1 then unit0");
   endtask

   task automatic test_timeout;
      bit ok;
      int cnt = 0;
      pulse_mounted(2'b01);
      wait_req(ok);
      while (sd_rd[0] && cnt < 200) begin
         cnt++;
         tick();
      end
      checks++;
      if (!ok || cnt !== 100) begin
         errors++;
         $display("FAIL timeout_len got ok=%b cycles=%0d want 100", ok, cnt);
      end
      checks++;
      if (error[0] !== 1'b1 || loaded[0] !== 1'b0 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL timeout_state got err=%b loaded=%b busy=%b want err0=1 ld0=0 busy0=0",
                  error, loaded, busy);
      end
      pulse_mounted(2'b01);
      checks++;
      if (error[0] !== 1'b0) begin
         errors++;
         $display("FAIL error_clear got err=%b want err0=0", error);
      end
      wait_req(ok);
      ack(0);
      $display("test_timeout done: %0d cycles", cnt);
   endtask

   task automatic test_toggle_during_xfer;
      bit ok;
      pulse_mounted(2'b10);
      wait_req(ok);
      sd_ack[1] = 1'b1;
      tick();
      save_track[0] = ~save_track[0];
      tick();
      sd_ack[1] = 1'b0;
      tick();
      wait_req(ok);
      checks++;
      if (!ok || sd_wr !== 2'b01 || sd_lba !== 32'd48 || buf_sel !== 1'b0) begin
         errors++;
         $display("FAIL save_after_xfer got ok=%b wr=%b lba=%0d sel=%b want wr=01 lba=48 sel=0",
                  ok, sd_wr, sd_lba, buf_sel);
      end
      ack(0);
      $display("test_toggle_during_xfer done");
   endtask

   task automatic test_remount;
      bit ok;
      pulse_mounted(2'b10);
      wait_req(ok);
      pulse_mounted(2'b10);
      ack(1);
      checks++;
      if (loaded[1] !== 1'b0 || busy[1] !== 1'b1) begin
         errors++;
         $display("FAIL remount_abort got loaded=%b busy=%b want ld1=0 busy1=1", loaded, busy);
      end
      wait_req(ok);
      checks++;
      if (!ok || sd_rd !== 2'b10) begin
         errors++;
         $display("FAIL remount_reload got ok=%b rd=%b want rd=10", ok, sd_rd);
      end
      ack(1);
      checks++;
      if (loaded[1] !== 1'b1) begin
         errors++;
         $display("FAIL remount_done got loaded=%b want ld1=1", loaded);
      end
      $display("test_remount done");
   endtask

   task automatic test_async_reset;
      bit ok;
      bit seen = 1'b0;
      pulse_mounted(2'b01);
      wait_req(ok);
      sd_ack[0] = 1'b1;
      tick();
      #1 reset_n = 1'b0;
      sd_ack[0] = 1'b0;
      #1;
      checks++;
      if ({sd_rd, sd_wr, busy, loaded, error, buf_sel} !== 11'd0 || sd_lba !== 32'd0) begin
         errors++;
         $display("FAIL async_reset got rd=%b wr=%b busy=%b ld=%b err=%b lba=%0d want all 0",
                  sd_rd, sd_wr, busy, loaded, error, sd_lba);
      end
      tick(2);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if ((sd_rd | sd_wr) != 2'b00 || busy != 2'b00) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_spurious got request_seen=%b want 0", seen);
      end
      $display("test_async_reset done");
   endtask

   initial begin
      test_reset();
      test_save_unloaded();
      test_load();
      test_save_then_load();
      test_round_robin();
      test_timeout();
      test_toggle_during_xfer();
      test_remount();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
